// File: rtl/lorenz_dda_integrator.sv
// Forward-Euler (DDA) integrator for the Lorenz attractor in signed fixed point.
// Each step takes STEP_DIV wait cycles, one multiply cycle and one update cycle.
module lorenz_dda_integrator #(
    parameter int WIDTH    = 27,
    parameter int FRAC     = 20,
    parameter int DT_SHIFT = 8,
    parameter int STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] z0,
    input  logic [31:0] sigma,
    input  logic [31:0] rho,
    input  logic [31:0] beta,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic        sample_valid,
    output logic [31:0] step_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] MUL    = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;

    localparam logic [31:0] DIV_LOAD = 32'(STEP_DIV - 1);

    logic [2:0]  state;
    logic [31:0] divider;

    logic signed [WIDTH-1:0] x, y, z;
    logic signed [WIDTH-1:0] p_sx, p_xr, p_xy, p_bz;
    logic signed [WIDTH-1:0] sigma_c, rho_c, beta_c;
    logic signed [WIDTH-1:0] d_yx, d_rz, d_py, d_pz;
    logic                    unused_hi;

    assign sigma_c = sigma[WIDTH-1:0];
    assign rho_c   = rho[WIDTH-1:0];
    assign beta_c  = beta[WIDTH-1:0];

    // Only the low WIDTH bits of each HPS word carry information.
    assign unused_hi = ^{x0[31:WIDTH], y0[31:WIDTH], z0[31:WIDTH],
                         sigma[31:WIDTH], rho[31:WIDTH], beta[31:WIDTH]};

    assign d_yx = y - x;
    assign d_rz = rho_c - z;
    assign d_py = p_xr - y;
    assign d_pz = p_xy - p_bz;

    assign x_out = {{(32-WIDTH){x[WIDTH-1]}}, x};
    assign y_out = {{(32-WIDTH){y[WIDTH-1]}}, y};
    assign z_out = {{(32-WIDTH){z[WIDTH-1]}}, z};

    // Full-precision product, re-aligned to FRAC bits by truncation (floor).
    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [2*WIDTH-1:0] full;
        full = a * b;
        return full[WIDTH+FRAC-1:FRAC];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            divider      <= '0;
            x            <= '0;
            y            <= '0;
            z            <= '0;
            p_sx         <= '0;
            p_xr         <= '0;
            p_xy         <= '0;
            p_bz         <= '0;
            step_count   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) state <= INIT;
                end
                INIT: begin
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        x          <= x0[WIDTH-1:0];
                        y          <= y0[WIDTH-1:0];
                        z          <= z0[WIDTH-1:0];
                        step_count <= '0;
                        divider    <= DIV_LOAD;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (divider == 32'd0) begin
                        state <= MUL;
                    end else begin
                        divider <= divider - 32'd1;
                    end
                end
                MUL: begin
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        p_sx  <= fx_mul(sigma_c, d_yx);
                        p_xr  <= fx_mul(x, d_rz);
                        p_xy  <= fx_mul(x, y);
                        p_bz  <= fx_mul(beta_c, z);
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    // Dropping run here discards the step entirely.
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        x            <= x + (p_sx >>> DT_SHIFT);
                        y            <= y + (d_py >>> DT_SHIFT);
                        z            <= z + (d_pz >>> DT_SHIFT);
                        step_count   <= step_count + 32'd1;
                        divider      <= DIV_LOAD;
                        sample_valid <= 1'b1;
                        state        <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lorenz_dda_integrator.sv
// Self-checking bench for lorenz_dda_integrator: directed steps plus randomized
// runs compared against an arithmetic Lorenz-step reference model.
module tb_lorenz_dda_integrator;

    localparam int WIDTH    = 27;
    localparam int FRAC     = 20;
    localparam int DT_SHIFT = 8;
    localparam int STEP_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] x0, y0, z0, sigma, rho, beta;
    logic [31:0] x_out, y_out, z_out, step_count;
    logic        sample_valid;

    int checks = 0;
    int errors = 0;

    longint mx, my, mz;
    longint msc;

    lorenz_dda_integrator #(
        .WIDTH(WIDTH), .FRAC(FRAC), .DT_SHIFT(DT_SHIFT), .STEP_DIV(STEP_DIV)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .x0(x0), .y0(y0), .z0(z0),
        .sigma(sigma), .rho(rho), .beta(beta),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .sample_valid(sample_valid), .step_count(step_count)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arithmetic: WIDTH-bit wraparound and floor-shifted products.
    function automatic longint wrap_w(input longint v);
        longint t;
        t = v & ((longint'(1) << WIDTH) - 1);
        if (t >= (longint'(1) << (WIDTH - 1))) t = t - (longint'(1) << WIDTH);
        return t;
    endfunction

    function automatic longint from_port(input logic [31:0] p);
        return wrap_w(longint'({32'b0, p}));
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return wrap_w((a * b) >>> FRAC);
    endfunction

    function automatic logic [31:0] to32(input longint v);
        return v[31:0];
    endfunction

    task automatic model_init();
        mx  = from_port(x0);
        my  = from_port(y0);
        mz  = from_port(z0);
        msc = 0;
    endtask

    task automatic model_step();
        longint sg, rh, bt, dx, dy, dz;
        sg = from_port(sigma);
        rh = from_port(rho);
        bt = from_port(beta);
        dx = qmul(sg, wrap_w(my - mx));
        dy = wrap_w(qmul(mx, wrap_w(rh - mz)) - my);
        dz = wrap_w(qmul(mx, my) - qmul(bt, mz));
        mx = wrap_w(mx + (dx >>> DT_SHIFT));
        my = wrap_w(my + (dy >>> DT_SHIFT));
        mz = wrap_w(mz + (dz >>> DT_SHIFT));
        msc = msc + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ix, input logic [31:0] iy,
                                 input logic [31:0] iz, input logic [31:0] s,
                                 input logic [31:0] r, input logic [31:0] b);
        x0 = ix; y0 = iy; z0 = iz;
        sigma = s; rho = r; beta = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, "_x"}, x_out, to32(mx));
        checkOutput({tag, "_y"}, y_out, to32(my));
        checkOutput({tag, "_z"}, z_out, to32(mz));
        checkOutput({tag, "_count"}, step_count, to32(msc));
    endtask

    // Ticks until sample_valid is seen; n is the number of edges it took.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sample_valid !== 1'b1 && n < 60);
    endtask

    initial begin
        int  n;
        int  bad;
        int  seen;
        reset = 1'b1;
        run   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        checkOutput("reset_x", x_out, 32'h0);
        checkOutput("reset_y", y_out, 32'h0);
        checkOutput("reset_z", z_out, 32'h0);
        checkOutput("reset_valid", 32'(sample_valid), 32'h0);
        checkOutput("reset_count", step_count, 32'h0);
        reset = 1'b0;
        tick();

        $display("[TB] unit step: x=1.0, sigma=1.0");
        applyStimulus(32'h00100000, 0, 0, 32'h00100000, 0, 0);
        run = 1'b1;
        tick();
        model_init();
        wait_valid(n);
        checkOutput("first_latency", 32'(n), 32'd7);
        model_step();
        checkOutput("unit_x", x_out, 32'h000FF000);
        check_model("unit_s1");
        for (int i = 2; i <= 4; i++) begin
            wait_valid(n);
            checkOutput($sformatf("period_%0d", i), 32'(n), 32'd6);
            model_step();
            check_model($sformatf("unit_s%0d", i));
        end

        $display("[TB] reset during UPDATE with run held high");
        repeat (5) tick();
        reset = 1'b1;
        tick();
        checkOutput("midreset_x", x_out, 32'h0);
        checkOutput("midreset_y", y_out, 32'h0);
        checkOutput("midreset_z", z_out, 32'h0);
        checkOutput("midreset_valid", 32'(sample_valid), 32'h0);
        checkOutput("midreset_count", step_count, 32'h0);
        reset = 1'b0;
        wait_valid(n);
        checkOutput("after_reset_latency", 32'(n), 32'd8);
        model_init();
        model_step();
        check_model("after_reset");
        run = 1'b0;
        repeat (2) tick();

        $display("[TB] zero initial state for 100 steps");
        applyStimulus(0, 0, 0, $urandom, $urandom, $urandom);
        run = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            wait_valid(n);
            if (n != ((i == 0) ? 7 : 6)) bad++;
            if (x_out !== 0 || y_out !== 0 || z_out !== 0) bad++;
        end
        checkOutput("zero_run_bad", 32'(bad), 32'd0);
        checkOutput("zero_run_count", step_count, 32'd100);
        run = 1'b0;
        repeat (2) tick();

        $display("[TB] classic Lorenz coefficients");
        applyStimulus(32'hFFF00000, 32'h00019999, 32'h01900000,
                      32'h00A00000, 32'h01C00000, 32'h002AAAAA);
        run = 1'b1;
        tick();
        model_init();
        wait_valid(n);
        model_step();
        checkOutput("lorenz_x1", x_out, 32'hFFF0AFFF);
        check_model("lorenz_s1");
        for (int i = 2; i <= 6; i++) begin
            wait_valid(n);
            model_step();
            check_model($sformatf("lorenz_s%0d", i));
        end
        run = 1'b0;
        repeat (2) tick();

        $display("[TB] drop run during MUL after 3 steps");
        run = 1'b1;
        tick();
        model_init();
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            model_step();
        end
        check_model("hold_before");
        repeat (4) tick();
        run = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sample_valid === 1'b1) seen++;
        end
        checkOutput("hold_no_pulse", 32'(seen), 32'd0);
        check_model("hold_after");
        run = 1'b1;
        repeat (2) tick();
        model_init();
        check_model("reload");
        wait_valid(n);
        model_step();
        check_model("reload_s1");
        run = 1'b0;
        repeat (2) tick();

        $display("[TB] randomized runs with mid-run coefficient changes");
        for (int t = 0; t < 3; t++) begin
            applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            run = 1'b1;
            tick();
            model_init();
            for (int i = 1; i <= 8; i++) begin
                wait_valid(n);
                model_step();
                check_model($sformatf("rand%0d_s%0d", t, i));
                if (i == 4) begin
                    sigma = $urandom;
                    rho   = $urandom;
                    beta  = $urandom;
                end
            end
            run = 1'b0;
            repeat (2) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
